// File: rtl/npu_pkg.sv
// ---------------------------------------------------------------------------
// npu_pkg
// Shared constants for the requantize / writeback stage.
//   state_t      : job controller states (ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE)
//   SHIFT_WIDTH  : width of the requant right-shift amount
//   DEF_Q_WIDTH  : default output lane width (unsigned)
// ---------------------------------------------------------------------------
package npu_pkg;

    localparam int SHIFT_WIDTH = 5;
    localparam int DEF_Q_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/requant_lane.sv
// ---------------------------------------------------------------------------
// requant_lane
// Combinational single-lane requantizer, split into two independent halves
// so the parent can register between them.
//   i_value   : signed lane input (two's complement)
//   i_shift   : right-shift amount, 0..31
//   o_rounded : max(value,0) after round-half-up right shift
//   i_rounded : registered copy of o_rounded from the parent's first stage
//   o_q       : i_rounded saturated to 2^Q_WIDTH-1
// ---------------------------------------------------------------------------
module requant_lane
    import npu_pkg::*;
#(
    parameter int OUT_WIDTH = 32,
    parameter int Q_WIDTH   = DEF_Q_WIDTH
) (
    input  logic [OUT_WIDTH-1:0]   i_value,
    input  logic [SHIFT_WIDTH-1:0] i_shift,
    output logic [OUT_WIDTH-1:0]   o_rounded,
    input  logic [OUT_WIDTH-1:0]   i_rounded,
    output logic [Q_WIDTH-1:0]     o_q
);

    localparam logic [OUT_WIDTH-1:0] QMAX = OUT_WIDTH'((2**Q_WIDTH) - 1);

    // Negatives clamp to zero here, so everything downstream is unsigned.
    // The sum gets one extra bit; a non-negative value plus half an LSB
    // can then never wrap.
    function automatic logic [OUT_WIDTH-1:0] round_shift(
        input logic [OUT_WIDTH-1:0]   v,
        input logic [SHIFT_WIDTH-1:0] sh
    );
        logic [OUT_WIDTH:0] sum;
        if (v[OUT_WIDTH-1]) return '0;
        if (sh == '0) return v;
        sum = {1'b0, v} + ((OUT_WIDTH+1)'(1) << (sh - SHIFT_WIDTH'(1)));
        return OUT_WIDTH'(sum >> sh);
    endfunction

    function automatic logic [Q_WIDTH-1:0] saturate(input logic [OUT_WIDTH-1:0] t);
        return (t > QMAX) ? '1 : t[Q_WIDTH-1:0];
    endfunction

    assign o_rounded = round_shift(i_value, i_shift);
    assign o_q       = saturate(i_rounded);

endmodule

// File: rtl/requant_writeback.sv
// ---------------------------------------------------------------------------
// requant_writeback
// Requantizes ARRAY_N signed lanes to unsigned Q_WIDTH bits, packs them and
// writes them out with an incrementing buffer address. A start/busy/done
// controller bounds each job to cfg_row_count vectors.
//   clk, reset      : clock, async active-high reset
//   start           : job start pulse (honoured in IDLE only)
//   cfg_shift       : rounding right-shift, latched at start
//   cfg_base_addr   : address of the first output word, latched at start
//   cfg_row_count   : vectors per job, latched at start (0 = empty job)
//   busy, done      : job in progress / one-cycle end-of-job pulse
//   in_data/valid/ready   : upstream vector handshake
//   out_data/addr/valid/ready : packed result handshake
// Two-stage pipeline: S1 = round/shift, S2 = saturate/pack (drives out_*).
// ---------------------------------------------------------------------------
module requant_writeback
    import npu_pkg::*;
#(
    parameter int ARRAY_N    = 16,
    parameter int OUT_WIDTH  = 32,
    parameter int Q_WIDTH    = DEF_Q_WIDTH,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [SHIFT_WIDTH-1:0]       cfg_shift,
    input  logic [ADDR_WIDTH-1:0]        cfg_base_addr,
    input  logic [ADDR_WIDTH-1:0]        cfg_row_count,
    output logic                         busy,
    output logic                         done,
    input  logic [ARRAY_N*OUT_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [ARRAY_N*Q_WIDTH-1:0]   out_data,
    output logic [ADDR_WIDTH-1:0]        out_addr,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int STAGES = 2;

    state_t                            r_state;
    logic                              r_busy, r_done;
    logic [SHIFT_WIDTH-1:0]            r_shift;
    logic [ADDR_WIDTH-1:0]             r_row_count, r_accepted, r_next_addr;

    logic [STAGES:1]                   r_vld_pipe;
    logic [ARRAY_N-1:0][OUT_WIDTH-1:0] r_s1_lane, w_s1_lane;
    logic [ADDR_WIDTH-1:0]             r_s1_addr, r_s2_addr;
    logic [ARRAY_N-1:0][Q_WIDTH-1:0]   r_s2_data, w_s2_data;

    logic w_s2_adv, w_s1_adv, w_accept, w_drain_last;

    // A stage may load when it is empty or its content leaves this cycle.
    assign w_s2_adv     = !r_vld_pipe[2] || out_ready;
    assign w_s1_adv     = !r_vld_pipe[1] || w_s2_adv;
    assign in_ready     = (r_state == ST_RUN) && w_s1_adv;
    assign w_accept     = in_valid && in_ready;
    // After this edge nothing is left: S1 is empty and S2 is empty or handing off.
    assign w_drain_last = !r_vld_pipe[1] && w_s2_adv;

    assign busy      = r_busy;
    assign done      = r_done;
    assign out_valid = r_vld_pipe[2];
    assign out_data  = r_s2_data;
    assign out_addr  = r_s2_addr;

    for (genvar g = 0; g < ARRAY_N; g++) begin : g_lane
        requant_lane #(
            .OUT_WIDTH (OUT_WIDTH),
            .Q_WIDTH   (Q_WIDTH)
        ) u_lane (
            .i_value   (in_data[g*OUT_WIDTH +: OUT_WIDTH]),
            .i_shift   (r_shift),
            .o_rounded (w_s1_lane[g]),
            .i_rounded (r_s1_lane[g]),
            .o_q       (w_s2_data[g])
        );
    end

    // Job controller with registered busy/done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_shift     <= '0;
            r_row_count <= '0;
            r_accepted  <= '0;
            r_next_addr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_shift     <= cfg_shift;
                        r_row_count <= cfg_row_count;
                        r_accepted  <= '0;
                        r_next_addr <= cfg_base_addr;
                        r_busy      <= 1'b1;
                        if (cfg_row_count != '0) begin
                            r_state <= ST_RUN;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        r_accepted  <= r_accepted + ADDR_WIDTH'(1);
                        r_next_addr <= r_next_addr + ADDR_WIDTH'(1);
                        // Leave RUN on the accepting edge so no extra vector slips in.
                        if (r_accepted + ADDR_WIDTH'(1) == r_row_count) r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_drain_last) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Data registers only load with valid content, so a stalled S2 holds steady.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_pipe <= '0;
            r_s1_lane  <= '0;
            r_s1_addr  <= '0;
            r_s2_data  <= '0;
            r_s2_addr  <= '0;
        end else begin
            if (w_s1_adv) begin
                r_vld_pipe[1] <= w_accept;
                if (w_accept) begin
                    r_s1_lane <= w_s1_lane;
                    r_s1_addr <= r_next_addr;
                end
            end
            if (w_s2_adv) begin
                r_vld_pipe[2] <= r_vld_pipe[1];
                if (r_vld_pipe[1]) begin
                    r_s2_data <= w_s2_data;
                    r_s2_addr <= r_s1_addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_requant_writeback.sv
// ---------------------------------------------------------------------------
// tb_requant_writeback
// Table-driven single-vector checks, hand-written corner sequences
// (wrap, stall, empty job, restart while busy, mid-job reset) and randomized
// jobs scored against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_requant_writeback;

    localparam int N  = 16;
    localparam int OW = 32;
    localparam int QW = 8;
    localparam int AW = 10;
    localparam int DW = N*OW;
    localparam int PW = N*QW;

    logic          clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic [4:0]    cfg_shift = '0;
    logic [AW-1:0] cfg_base_addr = '0, cfg_row_count = '0;
    logic          busy, done;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0, in_ready;
    logic [PW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_valid;
    logic          out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [AW-1:0] addr; logic [PW-1:0] data; int cyc; } exp_t;
    typedef struct { logic [4:0] sh; logic [31:0] val; logic [7:0] exp; } vec_t;

    vec_t tbl[$];

    requant_writeback #(
        .ARRAY_N(N), .OUT_WIDTH(OW), .Q_WIDTH(QW), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_shift(cfg_shift), .cfg_base_addr(cfg_base_addr), .cfg_row_count(cfg_row_count),
        .busy(busy), .done(done),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: clamp negatives, round half up by integer division, saturate.
    function automatic logic [7:0] ref_lane(input int sh, input logic [31:0] v);
        longint x;
        x = longint'($signed(v));
        if (x < 0) return 8'd0;
        if (sh > 0) x = (x + (longint'(1) << (sh - 1))) / (longint'(1) << sh);
        return (x > 255) ? 8'd255 : 8'(x);
    endfunction

    function automatic logic [PW-1:0] ref_word(input int sh, input logic [DW-1:0] d);
        logic [PW-1:0] w;
        w = '0;
        for (int i = 0; i < N; i++) w[i*QW +: QW] = ref_lane(sh, d[i*OW +: OW]);
        return w;
    endfunction

    function automatic logic [31:0] rand_lane();
        case ($urandom_range(0, 4))
            0:       return 32'($urandom_range(0, 600));
            1:       return $urandom;
            2:       return 32'h7FFF_FF00 | 32'($urandom_range(0, 255));
            3:       return 32'(0) - 32'($urandom_range(1, 1000));
            default: return 32'($urandom_range(0, 70000));
        endcase
    endfunction

    function automatic logic [DW-1:0] rand_vec();
        logic [DW-1:0] d;
        for (int i = 0; i < N; i++) d[i*OW +: OW] = rand_lane();
        return d;
    endfunction

    task automatic add(input logic [4:0] sh, input logic [31:0] val, input logic [7:0] exp);
        vec_t v;
        v.sh = sh; v.val = val; v.exp = exp;
        tbl.push_back(v);
    endtask

    // One-row job with a table value in one lane; checks exact 2-cycle latency.
    task automatic run_one(input vec_t v, input int lane);
        logic [DW-1:0] d;
        logic [AW-1:0] base;
        d = rand_vec();
        d[lane*OW +: OW] = v.val;
        base = AW'($urandom);
        @(posedge clk); #1;
        start = 1; cfg_shift = v.sh; cfg_base_addr = base; cfg_row_count = 1; out_ready = 1;
        @(posedge clk); #1;
        start = 0; cfg_shift = ~v.sh; cfg_base_addr = ~base; in_valid = 1; in_data = d;
        @(negedge clk); check("one_in_ready", in_ready, 1);
        @(posedge clk); #1; in_valid = 0;
        @(negedge clk); check("one_lat_t1", out_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("one_lat_t2", out_valid, 1);
        check("one_lane", out_data[lane*QW +: QW], v.exp);
        check("one_word", out_data, ref_word(v.sh, d));
        check("one_addr", out_addr, base);
        @(posedge clk); #1;
        @(negedge clk); check("one_done", {busy, done}, 2'b11);
        @(posedge clk); #1;
        @(negedge clk); check("one_idle", {busy, done}, 2'b00);
    endtask

    // General job: rmode 0 = ready always, 1 = random, 2 = 5-cycle stall at stall_at.
    task automatic run_job(input logic [4:0] sh, input logic [AW-1:0] base, input int rows,
                           input int rmode, input int vgap, input int stall_at, input int restart_at);
        exp_t q[$];
        exp_t e;
        int sent, got, cyc;
        bit pend, prev_stall;
        logic [DW-1:0] cur;
        logic [PW-1:0] prev_data;
        logic [AW-1:0] prev_addr;
        sent = 0; got = 0; cyc = 0; pend = 0; prev_stall = 0;
        cur = '0; prev_data = '0; prev_addr = '0;
        @(posedge clk); #1;
        start = 1; cfg_shift = sh; cfg_base_addr = base; cfg_row_count = AW'(rows);
        in_valid = 1; in_data = rand_vec(); out_ready = 1;
        @(negedge clk); check("idle_in_ready", in_ready, 0);
        @(posedge clk); #1;
        start = 0; cfg_shift = 5'($urandom); cfg_base_addr = AW'($urandom); cfg_row_count = '0;
        while (got < rows && cyc < 3000) begin
            if (!pend && sent < rows) begin cur = rand_vec(); pend = 1; end
            if (sent < rows) begin
                in_valid = (vgap == 0) || ($urandom_range(0, vgap) == 0);
                in_data  = cur;
            end else begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = rand_vec();
            end
            case (rmode)
                0:       out_ready = 1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = !(cyc >= stall_at && cyc < stall_at + 5);
            endcase
            start = (cyc == restart_at);
            @(negedge clk);
            check("busy", {busy, done}, 2'b10);
            check("in_ready", in_ready, (sent < rows) && ((sent - got) < 2 || out_ready));
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
                check("hold_addr", out_addr, prev_addr);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_out: got addr %0h expected no output", out_addr);
                end else begin
                    e = q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_addr", out_addr, e.addr);
                    if (rmode == 0 && vgap == 0) check("latency", cyc - e.cyc, 2);
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                e.addr = base + AW'(sent);
                e.data = ref_word(sh, cur);
                e.cyc  = cyc;
                q.push_back(e);
                sent++;
                pend = 0;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_addr  = out_addr;
            cyc++;
            @(posedge clk); #1;
        end
        start = 0; in_valid = 0;
        check("job_complete", got, rows);
        @(negedge clk);
        check("done_pulse", {busy, done}, 2'b11);
        check("no_extra_out", out_valid, 0);
        @(posedge clk); #1;
        @(negedge clk); check("done_end", {busy, done}, 2'b00);
    endtask

    initial begin
        add(5'd4,  32'd40,         8'd3);
        add(5'd4,  32'd8,          8'd1);
        add(5'd4,  32'd7,          8'd0);
        add(5'd4,  32'd4095,       8'd255);
        add(5'd0,  32'h7FFF_FFFF,  8'd255);
        add(5'd0,  32'hFFFF_FFF0,  8'd0);
        add(5'd0,  32'd200,        8'd200);
        add(5'd0,  32'd256,        8'd255);
        add(5'd0,  32'h8000_0000,  8'd0);
        add(5'd1,  32'd3,          8'd2);
        add(5'd1,  32'hFFFF_FFFF,  8'd0);
        add(5'd8,  32'h0000_FF7F,  8'd255);
        add(5'd8,  32'h0000_FF80,  8'd255);
        add(5'd8,  32'h0000_807F,  8'd128);
        add(5'd8,  32'h0000_0080,  8'd1);
        add(5'd8,  32'h0000_007F,  8'd0);
        add(5'd31, 32'h7FFF_FFFF,  8'd1);
        add(5'd31, 32'h4000_0000,  8'd1);
        add(5'd31, 32'h3FFF_FFFF,  8'd0);

        // Reset state
        #3 reset = 1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_addr", out_addr, 0);
        @(negedge clk); reset = 0;

        for (int i = 0; i < tbl.size(); i++) run_one(tbl[i], i % N);

        // Address wrap, continuous stream, exact done timing
        run_job(5'd4, 10'h3FE, 4, 0, 0, 0, -1);
        // Mid-stream backpressure
        run_job(5'd3, 10'h040, 6, 2, 0, 3, -1);
        // Start while running is ignored
        run_job(5'd2, 10'h120, 5, 0, 0, 0, 2);

        // Empty job, plus start while in DONE
        @(posedge clk); #1;
        start = 1; cfg_row_count = 0; cfg_base_addr = 10'h2AA; out_ready = 1;
        @(posedge clk); #1;
        cfg_row_count = 2;
        @(negedge clk);
        check("empty_done", {busy, done}, 2'b11);
        check("empty_no_out", out_valid, 0);
        @(posedge clk); #1; start = 0;
        @(negedge clk);
        check("empty_idle", {busy, done}, 2'b00);
        check("empty_no_out2", out_valid, 0);
        repeat (2) @(negedge clk);
        check("empty_still_idle", {busy, out_valid}, 2'b00);

        // Reset with two vectors in flight
        @(posedge clk); #1;
        start = 1; cfg_shift = 3; cfg_base_addr = 10'h100; cfg_row_count = 5; out_ready = 0;
        @(posedge clk); #1;
        start = 0; in_valid = 1; in_data = rand_vec();
        @(posedge clk); #1; in_data = rand_vec();
        @(posedge clk); #1; in_valid = 0;
        @(negedge clk); check("pre_rst_valid", {busy, out_valid}, 2'b11);
        @(posedge clk); #1; out_ready = 1;
        #1 check("pre_rst_in_ready", in_ready, 1);
        reset = 1;
        #1;
        check("async_out_valid", out_valid, 0);
        check("async_busy", busy, 0);
        check("async_in_ready", in_ready, 0);
        check("async_done", done, 0);
        @(negedge clk); reset = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_quiet", {done, out_valid, busy}, 3'b000);
        end
        run_job(5'd5, 10'h155, 3, 0, 0, 0, -1);

        // Randomized jobs
        for (int j = 0; j < 15; j++)
            run_job(5'($urandom), AW'($urandom), $urandom_range(1, 12), 1, 2, 0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
